// File: rtl/timer_pkg.sv
// Shared types and helpers for the BCD timer: state encoding, nibble width,
// and parameter-time helpers for the BCD limits.
package timer_pkg;

    localparam int BCD_NIBBLE = 4;
    localparam int MAX_DIGITS = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // All-nines BCD word for the requested digit count, right-aligned in 64 bits.
    function automatic logic [63:0] bcd_all_nines(input int digits);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < MAX_DIGITS; i++)
            if (i < digits) v[i*BCD_NIBBLE +: BCD_NIBBLE] = 4'd9;
        return v;
    endfunction

    function automatic logic bcd_limit_ok(input logic [63:0] v, input int digits);
        logic ok;
        ok = (v != 64'd0);
        for (int i = 0; i < MAX_DIGITS; i++)
            if (i < digits && v[i*BCD_NIBBLE +: BCD_NIBBLE] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/bcd_sub.sv
// Combinational DIGITS-wide BCD subtractor, o_diff = i_a - i_b, with the
// borrow rippling from the ones digit upward. Caller guarantees i_a >= i_b.
module bcd_sub
    import timer_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic [BCD_NIBBLE*DIGITS-1:0] i_a,
    input  logic [BCD_NIBBLE*DIGITS-1:0] i_b,
    output logic [BCD_NIBBLE*DIGITS-1:0] o_diff
);

    always_comb begin
        logic       w_borrow;
        logic [4:0] w_d;
        w_borrow = 1'b0;
        w_d      = '0;
        o_diff   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_d = {1'b0, i_a[i*BCD_NIBBLE +: BCD_NIBBLE]}
                - {1'b0, i_b[i*BCD_NIBBLE +: BCD_NIBBLE]}
                - {4'd0, w_borrow};
            // A negative 5-bit result means this digit borrowed: add ten back.
            if (w_d[4]) begin
                o_diff[i*BCD_NIBBLE +: BCD_NIBBLE] = w_d[3:0] + 4'd10;
                w_borrow = 1'b1;
            end else begin
                o_diff[i*BCD_NIBBLE +: BCD_NIBBLE] = w_d[3:0];
                w_borrow = 1'b0;
            end
        end
    end

endmodule

// File: rtl/bcd_rev_timer.sv
// Two-mode BCD timer: count-up display (mode A) or LIMIT_B-minus-count
// display (mode B), with start/pause/clear control, terminal pulse and wrap.
module bcd_rev_timer
    import timer_pkg::*;
#(
    parameter int                           DIGITS  = 2,
    parameter logic [BCD_NIBBLE*DIGITS-1:0] LIMIT_B = 'h59,
    parameter bit                           WRAP    = 1'b0
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_tick,
    input  logic                         i_start,
    input  logic                         i_pause,
    input  logic                         i_clear,
    input  logic                         i_mode_sel,
    output logic [BCD_NIBBLE*DIGITS-1:0] o_disp_out,
    output logic                         o_running,
    output logic                         o_done
);

    localparam int          W        = BCD_NIBBLE * DIGITS;
    localparam logic [W-1:0] LIMIT_A = W'(bcd_all_nines(DIGITS));
    localparam bit          LIMIT_OK = bcd_limit_ok(64'(LIMIT_B), DIGITS);

    state_t         r_state, w_state_nxt;
    logic [W-1:0]   r_count, w_count_nxt, w_count_inc, w_limit, w_disp_b;
    logic           r_mode_lat, w_mode_nxt;
    logic           r_done, w_done_nxt;

    assign w_limit = r_mode_lat ? LIMIT_B : LIMIT_A;

    always_comb begin
        logic w_carry;
        w_carry     = 1'b1;
        w_count_inc = r_count;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_carry) begin
                if (r_count[i*BCD_NIBBLE +: BCD_NIBBLE] == 4'd9) begin
                    w_count_inc[i*BCD_NIBBLE +: BCD_NIBBLE] = 4'd0;
                end else begin
                    w_count_inc[i*BCD_NIBBLE +: BCD_NIBBLE] =
                        r_count[i*BCD_NIBBLE +: BCD_NIBBLE] + 4'd1;
                    w_carry = 1'b0;
                end
            end
        end
    end

    // Priority: Clear > Pause > Start > Tick (Reset handled in the register).
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_mode_nxt  = r_mode_lat;
        w_done_nxt  = 1'b0;
        if (i_clear) begin
            w_state_nxt = IDLE;
            w_count_nxt = '0;
            w_mode_nxt  = 1'b0;
        end else if (i_pause) begin
            if (r_state == RUN) w_state_nxt = PAUSE;
        end else if (i_start && r_state != RUN) begin
            w_state_nxt = RUN;
            if (r_state != PAUSE) begin
                w_mode_nxt  = i_mode_sel;
                w_count_nxt = '0;
            end
        end else if (i_tick && r_state == RUN) begin
            if (WRAP) begin
                if (r_count == w_limit) begin
                    w_count_nxt = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_count_nxt = w_count_inc;
                end
            end else if (w_count_inc == w_limit) begin
                w_count_nxt = w_limit;
                w_state_nxt = DONE;
                w_done_nxt  = 1'b1;
            end else begin
                w_count_nxt = w_count_inc;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_mode_lat <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_mode_lat <= w_mode_nxt;
            r_done     <= w_done_nxt;
        end
    end

    bcd_sub #(.DIGITS(DIGITS)) u_sub (
        .i_a    (LIMIT_B),
        .i_b    (r_count),
        .o_diff (w_disp_b)
    );

    assign o_disp_out = r_mode_lat ? w_disp_b : r_count;
    assign o_running  = (r_state == RUN);
    assign o_done     = r_done;

    always @(posedge i_clk) begin
        assert (LIMIT_OK) else $fatal(1, "bcd_rev_timer: LIMIT_B must be nonzero BCD");
    end

endmodule

// File: tb/tb_bcd_rev_timer.sv
// Bench for bcd_rev_timer: three instances (default, WRAP=1, 3-digit 599)
// share one stimulus stream and are checked against closed-form and model values.
module tb_bcd_rev_timer;

    localparam int ST_IDLE = 0, ST_RUN = 1, ST_PAUSE = 2, ST_DONE = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b0, tick = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0, mode_sel = 1'b0;
    logic [7:0]  d0, d1;
    logic [11:0] d2;
    logic        run0, run1, run2, dn0, dn1, dn2;

    logic [11:0] dd [3];
    logic        rr [3];
    logic        dn [3];
    assign dd[0] = {4'd0, d0};
    assign dd[1] = {4'd0, d1};
    assign dd[2] = d2;
    assign rr[0] = run0;
    assign rr[1] = run1;
    assign rr[2] = run2;
    assign dn[0] = dn0;
    assign dn[1] = dn1;
    assign dn[2] = dn2;

    bcd_rev_timer u0 (
        .i_clk(clk), .i_reset(reset), .i_tick(tick), .i_start(start), .i_pause(pause),
        .i_clear(clear), .i_mode_sel(mode_sel), .o_disp_out(d0), .o_running(run0), .o_done(dn0)
    );
    bcd_rev_timer #(.WRAP(1'b1)) u1 (
        .i_clk(clk), .i_reset(reset), .i_tick(tick), .i_start(start), .i_pause(pause),
        .i_clear(clear), .i_mode_sel(mode_sel), .o_disp_out(d1), .o_running(run1), .o_done(dn1)
    );
    bcd_rev_timer #(.DIGITS(3), .LIMIT_B(12'h599)) u2 (
        .i_clk(clk), .i_reset(reset), .i_tick(tick), .i_start(start), .i_pause(pause),
        .i_clear(clear), .i_mode_sel(mode_sel), .o_disp_out(d2), .o_running(run2), .o_done(dn2)
    );

    int n_chk = 0, n_pass = 0;

    // Reference model: decimal count, spec-level state, per-instance parameters.
    int P_DIG  [3] = '{2, 2, 3};
    int P_LIMB [3] = '{59, 59, 599};
    int P_WRAP [3] = '{0, 1, 0};
    int m_st   [3] = '{0, 0, 0};
    int m_cnt  [3] = '{0, 0, 0};
    int m_mode [3] = '{0, 0, 0};
    int m_done [3] = '{0, 0, 0};

    function automatic int to_bcd(input int v);
        int r = 0;
        for (int i = 0; i < 4; i++) begin
            r += (v % 10) << (4 * i);
            v /= 10;
        end
        return r;
    endfunction

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r *= 10;
        return r;
    endfunction

    function automatic int m_disp(input int k);
        return m_mode[k] != 0 ? to_bcd(P_LIMB[k] - m_cnt[k]) : to_bcd(m_cnt[k]);
    endfunction

    task automatic step(input bit rst, input bit clr, input bit pse, input bit stt,
                        input bit tck, input bit ms);
        int lim;
        reset = rst; clear = clr; pause = pse; start = stt; tick = tck; mode_sel = ms;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            m_done[k] = 0;
            lim = m_mode[k] != 0 ? P_LIMB[k] : pow10(P_DIG[k]) - 1;
            if (rst || clr) begin
                m_st[k] = ST_IDLE; m_cnt[k] = 0; m_mode[k] = 0;
            end else if (pse) begin
                if (m_st[k] == ST_RUN) m_st[k] = ST_PAUSE;
            end else if (stt && m_st[k] != ST_RUN) begin
                if (m_st[k] != ST_PAUSE) begin
                    m_mode[k] = ms; m_cnt[k] = 0;
                end
                m_st[k] = ST_RUN;
            end else if (tck && m_st[k] == ST_RUN) begin
                if (P_WRAP[k] != 0) begin
                    if (m_cnt[k] == lim) begin m_cnt[k] = 0; m_done[k] = 1; end
                    else m_cnt[k]++;
                end else if (m_cnt[k] + 1 == lim) begin
                    m_cnt[k] = lim; m_st[k] = ST_DONE; m_done[k] = 1;
                end else m_cnt[k]++;
            end
        end
        #1;
        reset = 0; clear = 0; pause = 0; start = 0; tick = 0;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            n_chk++; if (dd[k] !== 12'h000) $display("FAIL reset_disp[%0d] got %h exp 000", k, dd[k]); else n_pass++;
            n_chk++; if (rr[k] !== 1'b0) $display("FAIL reset_running[%0d] got %b exp 0", k, rr[k]); else n_pass++;
            n_chk++; if (dn[k] !== 1'b0) $display("FAIL reset_done[%0d] got %b exp 0", k, dn[k]); else n_pass++;
        end
    endtask

    task automatic test_mode_b_countdown();
        int lim, c, e_d, e_dn, e_r;
        step(0, 0, 0, 1, 0, 1);
        n_chk++; if (d0 !== 8'h59) $display("FAIL b_start_disp got %h exp 59", d0); else n_pass++;
        n_chk++; if (d2 !== 12'h599) $display("FAIL b_start_disp3 got %h exp 599", d2); else n_pass++;
        for (int i = 1; i <= 600; i++) begin
            step(0, 0, 0, 0, 1, 1);
            for (int k = 0; k < 3; k++) begin
                lim  = (k == 2) ? 599 : 59;
                c    = (k == 1) ? i % 60 : (i < lim ? i : lim);
                e_d  = to_bcd(lim - c);
                e_dn = (k == 1) ? int'(i % 60 == 0) : int'(i == lim);
                e_r  = (k == 1) ? 1 : int'(i < lim);
                n_chk++; if (dd[k] !== e_d[11:0]) $display("FAIL b_disp[%0d] tick %0d got %h exp %h", k, i, dd[k], e_d[11:0]); else n_pass++;
                n_chk++; if (dn[k] !== e_dn[0]) $display("FAIL b_done[%0d] tick %0d got %b exp %b", k, i, dn[k], e_dn[0]); else n_pass++;
                n_chk++; if (rr[k] !== e_r[0]) $display("FAIL b_running[%0d] tick %0d got %b exp %b", k, i, rr[k], e_r[0]); else n_pass++;
            end
        end
    endtask

    task automatic test_mode_a_countup();
        int c, e_d, e_dn, e_r;
        step(0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            n_chk++; if (dd[k] !== 12'h000) $display("FAIL a_clear_disp[%0d] got %h exp 000", k, dd[k]); else n_pass++;
        end
        step(0, 0, 0, 1, 0, 0);
        for (int i = 1; i <= 100; i++) begin
            step(0, 0, 0, 0, 1, 1);
            for (int k = 0; k < 3; k++) begin
                c    = (k == 0) ? (i < 99 ? i : 99) : (k == 1) ? i % 100 : i;
                e_d  = to_bcd(c);
                e_dn = (k == 0) ? int'(i == 99) : (k == 1) ? int'(i == 100) : 0;
                e_r  = (k == 0) ? int'(i < 99) : 1;
                n_chk++; if (dd[k] !== e_d[11:0]) $display("FAIL a_disp[%0d] tick %0d got %h exp %h", k, i, dd[k], e_d[11:0]); else n_pass++;
                n_chk++; if (dn[k] !== e_dn[0]) $display("FAIL a_done[%0d] tick %0d got %b exp %b", k, i, dn[k], e_dn[0]); else n_pass++;
                n_chk++; if (rr[k] !== e_r[0]) $display("FAIL a_running[%0d] tick %0d got %b exp %b", k, i, rr[k], e_r[0]); else n_pass++;
            end
        end
    endtask

    task automatic test_pause();
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 1, 1);
        n_chk++; if (d0 !== 8'h47) $display("FAIL pause_pre got %h exp 47", d0); else n_pass++;
        step(0, 0, 1, 0, 1, 1);
        n_chk++; if (d0 !== 8'h47) $display("FAIL pause_tick_dropped got %h exp 47", d0); else n_pass++;
        n_chk++; if (run0 !== 1'b0) $display("FAIL pause_running got %b exp 0", run0); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 1, i[0]);
            n_chk++; if (d0 !== 8'h47) $display("FAIL pause_hold got %h exp 47", d0); else n_pass++;
            n_chk++; if (d2 !== 12'h587) $display("FAIL pause_hold3 got %h exp 587", d2); else n_pass++;
        end
        step(0, 0, 0, 1, 0, 0);
        n_chk++; if (d0 !== 8'h47) $display("FAIL resume_disp got %h exp 47", d0); else n_pass++;
        n_chk++; if (run0 !== 1'b1) $display("FAIL resume_running got %b exp 1", run0); else n_pass++;
        step(0, 0, 0, 0, 1, 0);
        n_chk++; if (d0 !== 8'h46) $display("FAIL resume_tick got %h exp 46", d0); else n_pass++;
        n_chk++; if (d1 !== 8'h46) $display("FAIL resume_tick_wrap got %h exp 46", d1); else n_pass++;
        n_chk++; if (d2 !== 12'h586) $display("FAIL resume_tick3 got %h exp 586", d2); else n_pass++;
        step(0, 0, 0, 0, 0, 1);
        n_chk++; if (d0 !== 8'h46) $display("FAIL modesel_toggle got %h exp 46", d0); else n_pass++;
    endtask

    task automatic test_clear_reset();
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 30; i++) step(0, 0, 0, 0, 1, 1);
        n_chk++; if (d0 !== 8'h29) $display("FAIL clr_pre got %h exp 29", d0); else n_pass++;
        step(0, 1, 0, 1, 0, 1);
        for (int k = 0; k < 3; k++) begin
            n_chk++; if (dd[k] !== 12'h000) $display("FAIL clr_start_disp[%0d] got %h exp 000", k, dd[k]); else n_pass++;
            n_chk++; if (rr[k] !== 1'b0) $display("FAIL clr_start_running[%0d] got %b exp 0", k, rr[k]); else n_pass++;
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 1, 1);
            n_chk++; if (d0 !== 8'h00) $display("FAIL clr_idle_tick got %h exp 00", d0); else n_pass++;
            n_chk++; if (run0 !== 1'b0) $display("FAIL clr_idle_running got %b exp 0", run0); else n_pass++;
        end
        step(0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 58; i++) step(0, 0, 0, 0, 1, 1);
        n_chk++; if (d0 !== 8'h01) $display("FAIL rst_pre got %h exp 01", d0); else n_pass++;
        step(1, 0, 0, 0, 1, 1);
        for (int k = 0; k < 3; k++) begin
            n_chk++; if (dd[k] !== 12'h000) $display("FAIL rst_mid_disp[%0d] got %h exp 000", k, dd[k]); else n_pass++;
            n_chk++; if (dn[k] !== 1'b0) $display("FAIL rst_mid_done[%0d] got %b exp 0", k, dn[k]); else n_pass++;
            n_chk++; if (rr[k] !== 1'b0) $display("FAIL rst_mid_running[%0d] got %b exp 0", k, rr[k]); else n_pass++;
        end
        step(0, 0, 0, 0, 1, 1);
        n_chk++; if (dn0 !== 1'b0) $display("FAIL rst_after_done got %b exp 0", dn0); else n_pass++;
    endtask

    task automatic test_random();
        int r, e_d;
        bit tk;
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            r  = int'($urandom_range(0, 199));
            tk = (r >= 17) && ($urandom_range(0, 3) != 0);
            step(r == 0, r >= 1 && r < 3, r >= 3 && r < 9, r >= 9 && r < 17, tk, 1'($urandom));
            for (int k = 0; k < 3; k++) begin
                e_d = m_disp(k);
                n_chk++; if (dd[k] !== e_d[11:0]) $display("FAIL rnd_disp[%0d] cyc %0d got %h exp %h", k, i, dd[k], e_d[11:0]); else n_pass++;
                n_chk++; if (dn[k] !== m_done[k][0]) $display("FAIL rnd_done[%0d] cyc %0d got %b exp %b", k, i, dn[k], m_done[k][0]); else n_pass++;
                n_chk++; if (rr[k] !== (m_st[k] == ST_RUN)) $display("FAIL rnd_running[%0d] cyc %0d got %b exp %b", k, i, rr[k], m_st[k] == ST_RUN); else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_mode_b_countdown();
        test_mode_a_countup();
        test_pause();
        test_clear_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bcd_rev_timer.md
Name: bcd_rev_timer

Overview:
Parametrised two-mode BCD timer core. Holds a DIGITS-digit BCD count that advances on a Tick enable and drives a display word.
- Mode A (ModeSel=0): count-up display; the display equals the count, range 0..10^DIGITS-1.
- Mode B (ModeSel=1): countdown display; the display equals LIMIT_B minus the count (BCD subtract with borrow), range LIMIT_B..0.

It sits between the tick prescaler and the 7-segment decoders. It adds start/pause/clear control, a latched mode, terminal detection and optional wrap.

Parameters:
- DIGITS, 2, number of BCD digits; the count and display width is 4*DIGITS.
- LIMIT_B, 8'h59, Mode B terminal count in BCD, 4*DIGITS bits wide; every nibble must be 0..9.
- WRAP, 0, 0 = stop in DONE at the terminal count; 1 = roll over to 0 and keep running.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- Tick  in  1  count enable, one-cycle pulse.
- Start  in  1  start/resume; samples ModeSel when leaving IDLE or DONE.
- Pause  in  1  hold the count.
- Clear  in  1  return to IDLE with count 0.
- ModeSel  in  1  0 = Mode A, 1 = Mode B.
- DispOut  out  4*DIGITS  BCD display word; nibble [3:0] is ones, [7:4] is tens, and so on.
- Running  out  1  high in RUN.
- Done  out  1  one-cycle terminal pulse.

Behaviour:
- Reset (synchronous, active-high), effective on the next edge: state=IDLE, Count=0, ModeLat=0, Done=0, Running=0, DispOut=0.
- Limit: Mode A uses all nibbles = 9 (99 for DIGITS=2). Mode B uses LIMIT_B.
- DispOut is combinational from registers and has no extra latency:
  - Mode A: DispOut = Count.
  - Mode B: DispOut = LIMIT_B - Count, digit-wise BCD subtract with borrow. It never goes negative because Count <= LIMIT_B.
- Count increments in BCD: a nibble at 9 goes to 0 with a carry into the next nibble. Nibble values 10..15 never occur.
- Control priority in every state: Reset > Clear > Pause > Start > Tick.
- IDLE:
  - Start: latch ModeLat=ModeSel, Count=0, go to RUN.
  - Tick, Pause: ignored.
- RUN, Running=1:
  - Clear: Count=0, go to IDLE.
  - Pause: go to PAUSE; a Tick in the same cycle is dropped.
  - Tick with Count < Limit-1: Count+1.
  - Tick with Count = Limit-1 and WRAP=0: Count=Limit, go to DONE, Done=1 for that one cycle.
  - Tick with Count = Limit and WRAP=1: Count=0, Done=1 for one cycle, stay in RUN.
  - Start: ignored; the mode does not change.
- PAUSE: Count held.
  - Start: go to RUN.
  - Clear: go to IDLE.
  - Tick: ignored.
- DONE: Count held at Limit, so Mode B shows all zeros.
  - Start: relatch ModeSel, Count=0, go to RUN.
  - Clear: go to IDLE.
- ModeSel is sampled only on Start from IDLE or DONE. Changing it in RUN or PAUSE has no effect on Count, Limit or DispOut.
- Done is a registered pulse that stays high for exactly one cycle. It never stays high across consecutive cycles without a new terminal event.
- Mid-operation reset or Clear: applies on the next edge, and no Done pulse is produced.
- Start and Clear in the same cycle: Clear wins, state goes to IDLE.
- Simulation assertion: any LIMIT_B nibble greater than 9, or LIMIT_B = 0, is a fatal error.

Decomposition:
- Shared package timer_pkg holds:
  - the state encoding enum: IDLE, RUN, PAUSE, DONE;
  - constant BCD_NIBBLE=4;
  - a helper function for the all-nines limit.
- Sub-module bcd_sub: combinational DIGITS-wide BCD subtractor (A - B with borrow chain). It produces the Mode B display and replaces the fixed 59-minus-input logic of the previous generation.
- The BCD incrementer stays inline in the top module.

Test Plan:
- Reset, then Start with ModeSel=1, then 59 Ticks. DispOut goes 59, 58, ..., 01, 00. On the 59th Tick, Done=1 for exactly one cycle and the state is DONE. Further Ticks hold DispOut=00.
- Start with ModeSel=0, then 100 Ticks. DispOut goes 00..99 with correct nibble carries at 09->10 and 89->90. Done is pulsed at 99 (WRAP=0), and DispOut holds 99.
- WRAP=1 with Mode B: 61 Ticks. DispOut shows 00 after Tick 59, then 59 after Tick 60 and 58 after Tick 61. Done pulses once, on Tick 60, and Running stays 1 throughout.
- Mode B run at Count=12 (DispOut=47): Pause together with a Tick, then 5 Ticks, then Start, then 1 Tick. DispOut holds 47 through the pause, then shows 46. Toggling ModeSel mid-run does not change DispOut.
- Mode B run at Count=30: Clear together with Start, then 3 Ticks. The block is in IDLE with DispOut=00 (Mode A, count 0) and the Ticks are ignored. Asserting Reset mid-run gives the same result, with no Done pulse.
- DIGITS=3, LIMIT_B=12'h599, Mode B: 600 Ticks. The display counts down from 599 to 000 with correct borrow across all three nibbles (e.g. 500->499, 100->099). Done pulses once.
